// File: rtl/seq_detector_prog_if.sv
// Signal bundle between a serial-bit source/config master and the programmable
// pattern detector.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic                 cfg_valid;
    logic [MAX_LEN-1:0]   cfg_pattern;
    logic [LEN_W-1:0]     cfg_len;
    logic                 cfg_overlap;
    logic                 cfg_err;
    logic                 in_valid;
    logic                 in_bit;
    logic                 clr_count;
    logic                 configured;
    logic                 detected;
    logic [CNT_W-1:0]     match_count;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap,
        output in_valid, in_bit, clr_count,
        input  cfg_err, configured, detected, match_count
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap,
        input  in_valid, in_bit, clr_count,
        output cfg_err, configured, detected, match_count
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial pattern detector: loadable pattern/length/overlap,
// one-cycle detect pulse and saturating match counter.
module seq_detector_prog #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_detector_prog_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {UNCFG, HUNT, HIT} state_t;

    state_t             state_reg, state_next;
    logic [MAX_LEN-1:0] hist_reg, hist_next;
    logic [LEN_W-1:0]   fill_reg, fill_next;
    logic [MAX_LEN-1:0] pattern_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               overlap_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               cfg_err_reg;
    logic               configured_reg;
    logic               detected_comb;

    logic               cfg_legal;
    logic               shift;
    logic               match;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;

    assign cfg_legal  = bus.cfg_valid && (bus.cfg_len != '0) &&
                        (bus.cfg_len <= LEN_W'(MAX_LEN));
    // A config strobe swallows any bit presented in the same cycle.
    assign shift      = bus.in_valid && !bus.cfg_valid && (state_reg != UNCFG);
    assign hist_shift = {hist_reg[MAX_LEN-2:0], bus.in_bit};
    assign fill_inc   = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_reg);
        end
    endgenerate

    assign match = shift && (fill_inc >= len_reg) &&
                   (((hist_shift ^ pattern_reg) & len_mask) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= UNCFG;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (cfg_legal)
            state_next = HUNT;
        else if (state_reg != UNCFG)
            state_next = match ? HIT : HUNT;
    end

    always_comb begin
        detected_comb = (state_reg == HIT);
    end

    always_comb begin
        hist_next = hist_reg;
        fill_next = fill_reg;
        if (cfg_legal) begin
            hist_next = '0;
            fill_next = '0;
        end else if (shift) begin
            hist_next = hist_shift;
            // Non-overlap mode forgets the history depth, so the next match needs len fresh bits.
            fill_next = (match && !overlap_reg) ? '0 : fill_inc;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (bus.clr_count)
            count_next = match ? CNT_W'(1) : '0;
        else if (match && (count_reg != {CNT_W{1'b1}}))
            count_next = count_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg       <= '0;
            fill_reg       <= '0;
            pattern_reg    <= '0;
            len_reg        <= '0;
            overlap_reg    <= 1'b0;
            count_reg      <= '0;
            cfg_err_reg    <= 1'b0;
            configured_reg <= 1'b0;
        end else begin
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            count_reg   <= count_next;
            cfg_err_reg <= bus.cfg_valid && !cfg_legal;
            if (cfg_legal) begin
                pattern_reg    <= bus.cfg_pattern;
                len_reg        <= bus.cfg_len;
                overlap_reg    <= bus.cfg_overlap;
                configured_reg <= 1'b1;
            end
        end
    end

    assign bus.cfg_err     = cfg_err_reg;
    assign bus.configured  = configured_reg;
    assign bus.detected    = detected_comb;
    assign bus.match_count = count_reg;
endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed, table-driven bench for seq_detector_prog (8-bit and 3-bit counter instances).
module tb_seq_detector_prog;
    logic clk;
    logic rst;

    seq_detector_prog_if #(.MAX_LEN(16), .CNT_W(8)) b();
    seq_detector_prog_if #(.MAX_LEN(16), .CNT_W(3)) b3();

    seq_detector_prog #(.MAX_LEN(16), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b));
    seq_detector_prog #(.MAX_LEN(16), .CNT_W(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    typedef struct {
        logic in_valid;
        logic in_bit;
        logic exp_det;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] stream;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_cfg(input logic [15:0] p, input logic [4:0] l, input logic ov);
        b.cfg_valid = 1'b1; b.cfg_pattern = p; b.cfg_len = l; b.cfg_overlap = ov;
        b.in_valid = 1'b0;
        step();
        b.cfg_valid = 1'b0;
        $display("cfg pattern=%h len=%0d overlap=%b configured=%b", p, l, ov, b.configured);
    endtask

    task automatic clr();
        b.clr_count = 1'b1; b.in_valid = 1'b0;
        step();
        b.clr_count = 1'b0;
        chk("clr_count", int'(b.match_count), 0);
    endtask

    task automatic feed(input string tag, input logic bitv, input logic exp_det);
        b.in_valid = 1'b1; b.in_bit = bitv;
        step();
        $display("%s bit=%b det=%b count=%0d", tag, bitv, b.detected, b.match_count);
        chk(tag, int'(b.detected), int'(exp_det));
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            b.in_valid = vecs[i].in_valid;
            b.in_bit   = vecs[i].in_bit;
            step();
            $display("%s vec %0d v=%b b=%b det=%b exp=%b", tag, i, vecs[i].in_valid,
                     vecs[i].in_bit, b.detected, vecs[i].exp_det);
            chk($sformatf("%s_det%0d", tag, i), int'(b.detected), int'(vecs[i].exp_det));
        end
        b.in_valid = 1'b0;
    endtask

    task automatic build_stream(input int h0, input int h1, input int h2);
        vecs.delete();
        for (int i = 0; i < 24; i++)
            vecs.push_back('{1'b1, stream[23-i], (i == h0) || (i == h1) || (i == h2)});
    endtask

    task automatic push(input logic v, input logic bv, input logic d);
        vecs.push_back('{v, bv, d});
    endtask

    initial begin
        stream = 24'b0011_0101_1001_1001_1010_1000;
        rst = 1'b0;
        b.cfg_valid = 0; b.cfg_pattern = '0; b.cfg_len = '0; b.cfg_overlap = 0;
        b.in_valid = 0; b.in_bit = 0; b.clr_count = 0;
        b3.cfg_valid = 0; b3.cfg_pattern = '0; b3.cfg_len = '0; b3.cfg_overlap = 0;
        b3.in_valid = 0; b3.in_bit = 0; b3.clr_count = 0;
        step(); step();
        chk("rst_configured", int'(b.configured), 0);
        chk("rst_detected", int'(b.detected), 0);
        chk("rst_count", int'(b.match_count), 0);
        chk("rst_cfg_err", int'(b.cfg_err), 0);
        rst = 1'b1;

        // Unconfigured: bits are ignored.
        vecs.delete();
        for (int i = 0; i < 6; i++) push(1'b1, (i != 2) && (i != 3), 1'b0);
        run_vecs("uncfg");
        chk("uncfg_count", int'(b.match_count), 0);
        chk("uncfg_configured", int'(b.configured), 0);

        do_cfg(16'h0033, 5'd6, 1'b1);
        chk("cfg_configured", int'(b.configured), 1);
        clr();
        build_stream(12, 16, -1);
        run_vecs("ov6");
        chk("ov6_count", int'(b.match_count), 2);

        do_cfg(16'h0033, 5'd6, 1'b0);
        clr();
        build_stream(12, -1, -1);
        run_vecs("nov6");
        chk("nov6_count", int'(b.match_count), 1);

        do_cfg(16'h000A, 5'd4, 1'b1);
        clr();
        build_stream(6, 19, 21);
        run_vecs("ov4");
        chk("ov4_count", int'(b.match_count), 3);

        do_cfg(16'h000A, 5'd4, 1'b0);
        build_stream(6, 19, -1);
        run_vecs("nov4");
        chk("nov4_count_no_clr_on_cfg", int'(b.match_count), 5);

        // "110011" with idle cycles between bits.
        do_cfg(16'h0033, 5'd6, 1'b0);
        clr();
        vecs.delete();
        push(1,1,0); push(0,0,0); push(1,1,0); push(0,1,0); push(0,0,0); push(1,0,0);
        push(1,0,0); push(0,1,0); push(1,1,0); push(0,0,0); push(1,1,1); push(0,0,0);
        push(0,0,0);
        run_vecs("gaps");
        chk("gaps_count", int'(b.match_count), 1);

        // Illegal lengths mid-pattern leave config and history intact.
        feed("ill_a", 1'b1, 1'b0);
        feed("ill_b", 1'b1, 1'b0);
        feed("ill_c", 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            b.cfg_valid = 1'b1; b.cfg_len = (k == 0) ? 5'd0 : 5'd17;
            b.cfg_pattern = 16'hFFFF; b.in_valid = 1'b1; b.in_bit = 1'b1;
            step();
            $display("illegal cfg len=%0d cfg_err=%b", b.cfg_len, b.cfg_err);
            chk("cfg_err_pulse", int'(b.cfg_err), 1);
            b.cfg_valid = 1'b0; b.in_valid = 1'b0;
            step();
            chk("cfg_err_drop", int'(b.cfg_err), 0);
        end
        feed("ill_d", 1'b0, 1'b0);
        feed("ill_e", 1'b1, 1'b0);
        feed("ill_f", 1'b1, 1'b1);
        b.in_valid = 1'b0;
        chk("ill_count", int'(b.match_count), 2);
        chk("ill_configured", int'(b.configured), 1);

        // Config and bit in the same cycle: the bit is dropped.
        b.cfg_valid = 1'b1; b.cfg_pattern = 16'h0003; b.cfg_len = 5'd2; b.cfg_overlap = 1'b1;
        b.in_valid = 1'b1; b.in_bit = 1'b1;
        step();
        b.cfg_valid = 1'b0;
        feed("prio_a", 1'b1, 1'b0);
        feed("prio_b", 1'b1, 1'b1);
        b.in_valid = 1'b0;

        // Async reset while detected is high.
        do_cfg(16'h000A, 5'd4, 1'b1);
        clr();
        feed("rst_a", 1'b1, 1'b0);
        feed("rst_b", 1'b0, 1'b0);
        feed("rst_c", 1'b1, 1'b0);
        feed("rst_d", 1'b0, 1'b1);
        b.in_valid = 1'b0;
        chk("pre_rst_count", int'(b.match_count), 1);
        rst = 1'b0;
        #1;
        chk("async_rst_detected", int'(b.detected), 0);
        chk("async_rst_count", int'(b.match_count), 0);
        chk("async_rst_configured", int'(b.configured), 0);
        #3;
        rst = 1'b1;
        feed("post_rst_a", 1'b1, 1'b0);
        feed("post_rst_b", 1'b0, 1'b0);
        feed("post_rst_c", 1'b1, 1'b0);
        feed("post_rst_d", 1'b0, 1'b0);
        b.in_valid = 1'b0;
        chk("post_rst_count", int'(b.match_count), 0);
        chk("post_rst_configured", int'(b.configured), 0);

        // len=1 saturation on the 3-bit counter instance.
        b3.cfg_valid = 1'b1; b3.cfg_pattern = 16'h0001; b3.cfg_len = 5'd1; b3.cfg_overlap = 1'b1;
        step();
        b3.cfg_valid = 1'b0;
        chk("sat_configured", int'(b3.configured), 1);
        for (int i = 0; i < 10; i++) begin
            b3.in_valid = 1'b1; b3.in_bit = 1'b1;
            step();
            $display("sat bit %0d det=%b count=%0d", i, b3.detected, b3.match_count);
            chk($sformatf("sat_det%0d", i), int'(b3.detected), 1);
            chk($sformatf("sat_cnt%0d", i), int'(b3.match_count), (i + 1 > 7) ? 7 : i + 1);
        end
        b3.clr_count = 1'b1;
        step();
        $display("sat clr+match det=%b count=%0d", b3.detected, b3.match_count);
        chk("clr_with_match_count", int'(b3.match_count), 1);
        chk("clr_with_match_det", int'(b3.detected), 1);
        b3.clr_count = 1'b0; b3.in_bit = 1'b0;
        step();
        chk("sat_zero_det", int'(b3.detected), 0);
        chk("sat_zero_count", int'(b3.match_count), 1);
        b3.in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
